// File: rtl/enemies_pkg.sv
// Shared types and constants for the enemy collision logic.
package enemies_pkg;

  localparam int NUM_ENEMIES_MAX        = 8;
  localparam int FIXED_POINT_MULTIPLIER = 64;

  typedef logic [NUM_ENEMIES_MAX-1:0] enemy_mask_t;

  typedef enum logic {
    COLLECT = 1'b0,
    ISSUE   = 1'b1
  } det_state_t;

  // Keeps only the lowest set bit of the mask (two's-complement isolate).
  function automatic enemy_mask_t lowest_one_hot(input enemy_mask_t m);
    return m & (~m + enemy_mask_t'(1));
  endfunction

endpackage

// File: rtl/collision_frame_latch.sv
// Per-enemy sticky hit/bounce latches. The strobe pixel starts a new frame,
// so on startOfFrame the latches reload instead of accumulating.
module collision_frame_latch (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic hit,
  input  logic bounce,
  output logic hitL,
  output logic bounceL
);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hitL    <= 1'b0;
      bounceL <= 1'b0;
    end else if (startOfFrame) begin
      hitL    <= hit;
      bounceL <= bounce;
    end else begin
      hitL    <= hitL | hit;
      bounceL <= bounceL | bounce;
    end
  end

endmodule

// File: rtl/enemies_collision_detector.sv
// Frame-based collision detector: latches shot/border/enemy overlaps during a
// frame and issues one-cycle kill/bounce pulses right after startOfFrame.
module enemies_collision_detector
  import enemies_pkg::*;
#(
  parameter int NUM_ENEMIES       = 4,
  parameter int SHOT_BLANK_FRAMES = 3,
  parameter int SCORE_WIDTH       = 8
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic [NUM_ENEMIES-1:0] enemyDrawingRequest,
  input  logic                   shotDrawingRequest,
  input  logic                   borderDrawingRequest,
  output logic [NUM_ENEMIES-1:0] shotCollision,
  output logic [NUM_ENEMIES-1:0] changeDirection,
  output logic                   shotHit,
  output logic [NUM_ENEMIES-1:0] aliveMask,
  output logic [SCORE_WIDTH-1:0] killCount,
  output logic                   allDead,
  output det_state_t             detState
);

  localparam int BLANK_W = (SHOT_BLANK_FRAMES < 1) ? 1 : $clog2(SHOT_BLANK_FRAMES + 1);
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(SHOT_BLANK_FRAMES);

  det_state_t             state, state_next;
  logic                   issue_event;
  logic [BLANK_W-1:0]     blank_cnt;
  logic                   blank_clear;
  logic [NUM_ENEMIES-1:0] active;
  logic [NUM_ENEMIES-1:0] hit, bounce;
  logic [NUM_ENEMIES-1:0] hit_l, bounce_l;
  logic [NUM_ENEMIES-1:0] kill_oh;
  logic                   any_kill;

  // Dead enemies vanish from detection, also as bounce partners.
  assign active      = enemyDrawingRequest & aliveMask;
  assign blank_clear = (blank_cnt == '0);

  for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_enemy
    localparam logic [NUM_ENEMIES-1:0] SELF = NUM_ENEMIES'(1) << i;
    logic others;

    assign others    = |(active & ~SELF);
    assign hit[i]    = active[i] & shotDrawingRequest & blank_clear;
    assign bounce[i] = active[i] & (borderDrawingRequest | others);

    collision_frame_latch u_latch (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .hit          (hit[i]),
      .bounce       (bounce[i]),
      .hitL         (hit_l[i]),
      .bounceL      (bounce_l[i])
    );
  end

  // The shot is a single object, so only the lowest-index hit becomes a kill.
  assign kill_oh  = NUM_ENEMIES'(lowest_one_hot(enemy_mask_t'(hit_l & aliveMask)));
  assign any_kill = |kill_oh;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = COLLECT;
    issue_event = 1'b0;
    case (state)
      COLLECT: begin
        if (startOfFrame) begin
          state_next  = ISSUE;
          issue_event = 1'b1;
        end
      end
      ISSUE: begin
        if (startOfFrame) begin
          state_next  = ISSUE;
          issue_event = 1'b1;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  // Pulses are registered so they are high exactly during the ISSUE cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shotCollision   <= '0;
      changeDirection <= '0;
      shotHit         <= 1'b0;
    end else if (issue_event) begin
      shotCollision   <= kill_oh;
      changeDirection <= bounce_l & aliveMask & ~kill_oh;
      shotHit         <= any_kill;
    end else begin
      shotCollision   <= '0;
      changeDirection <= '0;
      shotHit         <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      aliveMask <= '1;
      killCount <= '0;
      blank_cnt <= '0;
    end else if (issue_event) begin
      if (any_kill) begin
        aliveMask <= aliveMask & ~kill_oh;
        killCount <= (killCount == '1) ? killCount : killCount + SCORE_WIDTH'(1);
        blank_cnt <= BLANK_LOAD;
      end else if (!blank_clear) begin
        blank_cnt <= blank_cnt - BLANK_W'(1);
      end
    end
  end

  assign allDead  = ~|aliveMask;
  assign detState = state;

endmodule

// File: tb/tb_enemies_collision_detector.sv
// Directed and randomized frames against a frame-level reference model.
module tb_enemies_collision_detector;
  import enemies_pkg::*;

  localparam int N          = 4;
  localparam int SHOT_BLANK = 3;
  localparam int W          = 26;

  // clock / reset
  logic clk = 1'b0;
  logic resetN = 1'b1;
  always #5 clk = ~clk;

  logic         startOfFrame = 1'b0;
  logic         shot = 1'b0;
  logic         border = 1'b0;
  logic [N-1:0] en = '0;

  logic [N-1:0] sc, cd, alive;
  logic         sh, dead;
  logic [7:0]   kc8;
  det_state_t   st;
  logic [N-1:0] sc2, cd2, alive2;
  logic         sh2, dead2;
  logic [1:0]   kc2;
  det_state_t   st2;

  enemies_collision_detector #(.NUM_ENEMIES(N), .SHOT_BLANK_FRAMES(SHOT_BLANK), .SCORE_WIDTH(8)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .enemyDrawingRequest(en), .shotDrawingRequest(shot), .borderDrawingRequest(border),
    .shotCollision(sc), .changeDirection(cd), .shotHit(sh), .aliveMask(alive),
    .killCount(kc8), .allDead(dead), .detState(st)
  );

  enemies_collision_detector #(.NUM_ENEMIES(N), .SHOT_BLANK_FRAMES(SHOT_BLANK), .SCORE_WIDTH(2)) dut_sw2 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .enemyDrawingRequest(en), .shotDrawingRequest(shot), .borderDrawingRequest(border),
    .shotCollision(sc2), .changeDirection(cd2), .shotHit(sh2), .aliveMask(alive2),
    .killCount(kc2), .allDead(dead2), .detState(st2)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // reference model state: frame-level sets of enemies hit / bounced
  logic [N-1:0] m_alive, m_hitf, m_bncf;
  int m_kills, m_blank;

  function automatic logic [W-1:0] pack_exp(input logic issue, input logic [N-1:0] e_sc,
                                            input logic [N-1:0] e_cd, input logic e_sh,
                                            input logic [N-1:0] e_al, input int kills);
    logic [7:0] k8;
    logic [1:0] k2;
    logic       d;
    k8 = (kills > 255) ? 8'd255 : 8'(kills);
    k2 = (kills > 3) ? 2'd3 : 2'(kills);
    d  = (e_al == 0);
    return {issue, e_sc, e_cd, e_sh, e_al, k8, k2, d, d};
  endfunction

  task automatic model_reset();
    m_alive = '1;
    m_hitf  = '0;
    m_bncf  = '0;
    m_kills = 0;
    m_blank = 0;
  endtask

  task automatic model_step(input logic [N-1:0] e, input logic s, input logic b, input logic f);
    logic [N-1:0] act, ph, pb, e_sc, e_cd;
    logic e_sh;
    int kill;
    act = e & m_alive;
    for (int i = 0; i < N; i++) begin
      ph[i] = act[i] && s && (m_blank == 0);
      pb[i] = act[i] && (b || ($countones(act) > 1));
    end
    e_sc = '0;
    e_cd = '0;
    e_sh = 1'b0;
    if (f) begin
      kill = -1;
      for (int i = N - 1; i >= 0; i--) if (m_hitf[i] && m_alive[i]) kill = i;
      e_cd = m_bncf & m_alive;
      if (kill >= 0) begin
        e_sc[kill]    = 1'b1;
        e_sh          = 1'b1;
        e_cd[kill]    = 1'b0;
        m_alive[kill] = 1'b0;
        m_kills++;
        m_blank = SHOT_BLANK;
      end else if (m_blank > 0) begin
        m_blank--;
      end
      m_hitf = ph;
      m_bncf = pb;
    end else begin
      m_hitf = m_hitf | ph;
      m_bncf = m_bncf | pb;
    end
    exp_q.push_back(pack_exp(f, e_sc, e_cd, e_sh, m_alive, m_kills));
  endtask

  // scoreboard
  task automatic check_outputs(input string tag);
    logic [W-1:0] exp_v, obs_v;
    obs_v = {st == ISSUE, sc, cd, sh, alive, kc8, kc2, dead, dead2};
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s no expected entry observed=%h", tag, obs_v);
    end else begin
      exp_v = exp_q.pop_front();
      checks++;
      assert (obs_v === exp_v) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // drivers
  task automatic cycle(input logic [N-1:0] e, input logic s, input logic b, input logic f,
                       input string tag);
    en = e;
    shot = s;
    border = b;
    startOfFrame = f;
    model_step(e, s, b, f);
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle('0, 1'b0, 1'b0, 1'b0, "idle");
  endtask

  task automatic frame_end(input string tag);
    cycle('0, 1'b0, 1'b0, 1'b1, tag);
  endtask

  task automatic reset_dut(input string tag);
    en = '0;
    shot = 1'b0;
    border = 1'b0;
    startOfFrame = 1'b0;
    resetN = 1'b0;
    model_reset();
    #1;
    exp_q.push_back(pack_exp(1'b0, '0, '0, 1'b0, '1, 0));
    check_outputs(tag);
    @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    reset_dut("reset");
    frame_end("sof0");

    // enemy 2 shot over 5 pixels
    idle(3);
    for (int k = 0; k < 5; k++) cycle(4'b0100, 1'b1, 1'b0, 1'b0, "t1_px");
    idle(2);
    frame_end("t1_sof");
    check_val("t1_sc", 8'(sc), 8'b0100);
    check_val("t1_shothit", 8'(sh), 8'd1);
    check_val("t1_alive", 8'(alive), 8'b1011);
    check_val("t1_kc", kc8, 8'd1);
    idle(1);
    check_val("t1_pulse_width", 8'(sc), 8'd0);

    // blanking: three frames of shot over enemy 0 are ignored
    for (int f = 0; f < 3; f++) begin
      idle(2);
      cycle(4'b0001, 1'b1, 1'b0, 1'b0, "blank_px");
      idle(1);
      frame_end("blank_sof");
      check_val("blank_sc", 8'(sc), 8'd0);
    end
    cycle(4'b0001, 1'b1, 1'b0, 1'b0, "t3_px");
    frame_end("t3_sof");
    check_val("t3_sc", 8'(sc), 8'b0001);
    check_val("t3_alive", 8'(alive), 8'b1010);
    for (int f = 0; f < 3; f++) begin
      idle(1);
      frame_end("gap");
    end

    // shot over enemies 1 and 3 in one frame
    cycle(4'b0010, 1'b1, 1'b0, 1'b0, "t2_px1");
    idle(1);
    cycle(4'b1000, 1'b1, 1'b0, 1'b0, "t2_px3");
    frame_end("t2_sof");
    check_val("t2_sc", 8'(sc), 8'b0010);
    check_val("t2_alive", 8'(alive), 8'b1000);
    for (int f = 0; f < 3; f++) begin
      idle(1);
      frame_end("gap");
    end

    // fourth kill: saturation of the 2-bit counter and allDead
    cycle(4'b1000, 1'b1, 1'b0, 1'b0, "sat_px");
    frame_end("sat_sof");
    check_val("sat_kc8", kc8, 8'd4);
    check_val("sat_kc2", 8'(kc2), 8'd3);
    check_val("sat_dead", 8'(dead), 8'd1);
    cycle(4'b1111, 1'b1, 1'b1, 1'b0, "dead_px");
    frame_end("dead_sof");
    check_val("dead_cd", 8'(cd), 8'd0);
    check_val("dead_sh", 8'(sh), 8'd0);

    // bounces: border on 0, enemies 1/2 overlapping
    reset_dut("reset_b");
    frame_end("b_sof0");
    cycle(4'b0001, 1'b0, 1'b1, 1'b0, "b_border");
    cycle(4'b0110, 1'b0, 1'b0, 1'b0, "b_overlap");
    idle(1);
    frame_end("b_sof");
    check_val("b_cd", 8'(cd), 8'b0111);
    idle(1);
    check_val("b_cd_width", 8'(cd), 8'd0);

    // dead enemy 1 over enemy 2
    cycle(4'b0010, 1'b1, 1'b0, 1'b0, "d_kill_px");
    frame_end("d_kill_sof");
    check_val("d_kill_sc", 8'(sc), 8'b0010);
    for (int f = 0; f < 3; f++) begin
      idle(1);
      frame_end("gap");
    end
    cycle(4'b0010, 1'b1, 1'b0, 1'b0, "d_shot_dead");
    cycle(4'b0110, 1'b0, 1'b0, 1'b0, "d_overlap");
    frame_end("d_sof");
    check_val("d_cd", 8'(cd), 8'd0);
    check_val("d_sc", 8'(sc), 8'd0);

    // reset in the middle of a frame with pending overlaps
    reset_dut("reset_m");
    frame_end("m_sof0");
    for (int k = 0; k < 3; k++) cycle(4'b0100, 1'b1, 1'b0, 1'b0, "m_px");
    cycle(4'b0011, 1'b0, 1'b1, 1'b0, "m_bounce");
    reset_dut("reset_mid");
    idle(2);
    frame_end("m_sof");
    check_val("m_sc", 8'(sc), 8'd0);
    check_val("m_cd", 8'(cd), 8'd0);
    check_val("m_alive", 8'(alive), 8'b1111);
    check_val("m_kc", kc8, 8'd0);

    // double strobe: second issue sees only the strobe pixel
    idle(1);
    cycle(4'b0001, 1'b0, 1'b1, 1'b0, "ds_px");
    cycle(4'b0010, 1'b0, 1'b1, 1'b1, "ds_sof1");
    check_val("ds_cd1", 8'(cd), 8'b0001);
    frame_end("ds_sof2");
    check_val("ds_cd2", 8'(cd), 8'b0010);
    idle(1);
    check_val("ds_cd3", 8'(cd), 8'd0);

    // randomized frames
    for (int ep = 0; ep < 4; ep++) begin
      reset_dut("reset_r");
      frame_end("r_sof0");
      for (int f = 0; f < 10; f++) begin
        for (int p = 0; p < 14; p++) begin
          logic [N-1:0] re;
          logic rs, rb;
          re = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0;
          rs = ($urandom_range(0, 5) == 0);
          rb = ($urandom_range(0, 7) == 0);
          cycle(re, rs, rb, 1'b0, "r_px");
        end
        frame_end("r_sof");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
